nexi_uart_tx_serializer: RTL and testbench
==========================================

// Module: nexi_uart_tx_serializer
// PURPOSE
//  UART transmit stage downstream of the nexi 16550a-style wishbone UART. Accepts one byte per
//  command_send/done_ack four-phase handshake, latches it, and shifts it out LSB-first on tx_pin
//  as start / data / [parity] / stop bits. The bit clock comes from an internal baud divider
//  running on the system clock.
// PARAMETERS
//  CLK_FREQ_HZ  50_000_000  system clock frequency
//  BAUD         115200      line rate; DIV = (CLK_FREQ_HZ + BAUD/2) / BAUD clocks per bit, DIV >= 2
//  DATA_WIDTH   8           data bits per frame (5..8)
//  PARITY_EN    0           1: insert parity bit after data
//  PARITY_ODD   0           1: odd parity, 0: even (only when PARITY_EN=1)
//  STOP_BITS    1           1 or 2 stop bits
// PORTS
//  clk_i         in   1           system clock
//  rst_i         in   1           asynchronous reset, active-high
//  command_send  in   1           request: level-high means data is valid, start a frame
//  data          in   DATA_WIDTH  byte to send; sampled only in the acceptance cycle
//  done_ack      out  1           1 = idle or frame finished; 0 = frame accepted and in progress
//  busy_o        out  1           1 while any frame bit is on the line
//  tx_pin        out  1           serial line, idle high
// BEHAVIOUR
//  - Clock and reset: one clock domain, clk_i. Reset is asynchronous and active-high (rst_i).
//  - Reset values: tx_pin=1, done_ack=1, busy_o=0. FSM goes to IDLE, baud counter and bit
//    counter to 0, shift register to 0.
//  - Reset mid-frame: the frame is aborted immediately and tx_pin returns to 1. No resume.
//  - FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
//  - IDLE: done_ack=1. When command_send=1, the shift register latches data and the FSM goes to
//    START in the same edge. done_ack drops to 0 and tx_pin drops to 0 on that edge, so the
//    start bit begins 1 clock after command_send is sampled high.
//  - Each of START, DATA bits, PARITY and STOP lasts exactly DIV clocks.
//    - The baud counter reloads at every state or bit change.
//    - A bit ends when the counter reaches DIV-1.
//  - DATA: tx_pin = shreg[0]; shift right at the end of each bit. Bit counter runs
//    0..DATA_WIDTH-1, then the FSM goes to PARITY if PARITY_EN, else to STOP.
//  - PARITY: tx_pin = ^latched_data ^ PARITY_ODD, computed over the latched byte, not the
//    shifted value.
//  - STOP: tx_pin=1 for STOP_BITS*DIV clocks, then the FSM goes to DONE.
//  - DONE: done_ack=1, busy_o=0, tx_pin=1. Stays in DONE until command_send=0, then goes to IDLE.
//    This prevents a held request from re-sending the byte. A fresh request therefore needs
//    command_send low for at least 1 clock.
//  - command_send and data changes while the FSM is in START..STOP are ignored.
//    data is not re-sampled.
//  - busy_o=1 exactly in START, DATA, PARITY and STOP.
//  - Throughput: one frame = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS)*DIV clocks, plus 2 clocks
//    of handshake overhead (DONE->IDLE, IDLE->START).
//  - Widths: counter width = $clog2(DIV). Bit counter width = $clog2(DATA_WIDTH+1).
//    All compares are unsigned with no wrap. Counters never run past their terminal value.
// STRUCTURE
//  - Shared package nexi_uart_pkg holds the FSM state encoding (one-hot localparams for
//    S_TX_IDLE..S_TX_DONE), the divisor function uart_div(clk, baud), and the frame-length
//    helper. The wishbone UART and the receiver reuse these.
//  - One sub-module: nexi_uart_baud_gen. It takes clear and enable and produces a one-cycle
//    bit_tick every DIV clocks. The receiver instantiates it with DIV/16.
//  - All remaining logic (FSM, shift register, parity) stays in this file.
// TESTING (bench: CLK_FREQ_HZ=16, BAUD=1 -> DIV=16; check tx_pin with a bit-period sampler)
//  1. Reset, then command_send=1 with data=8'hA5, dropped when done_ack=0 -> tx_pin shows
//     0,1,0,1,0,0,1,0,1,1 at 16 clocks/bit; done_ack returns to 1 exactly 160 clocks after
//     the start bit.
//  2. command_send held high through the whole frame with data=8'h3C -> exactly one frame is
//     sent; FSM waits in DONE; a second frame starts only after a low cycle and a new high.
//  3. data changed 8'h00 -> 8'hFF during the DATA bits of an 8'h00 frame -> line shows all-zero
//     data bits.
//  4. PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, data=8'h07 -> parity bit 1, then 32 clocks high,
//     frame = 192 clocks.
//  5. rst_i asserted asynchronously (between clock edges) during data bit 3 -> tx_pin=1,
//     done_ack=1 and busy_o=0 immediately; the next request sends a complete, correct frame.
//  6. Back-to-back 8'h55 / 8'hAA through the four-phase handshake -> frames contiguous except
//     2 idle-high clocks; decoded bytes match.

Source files
------------

// File: rtl/nexi_uart_pkg.sv
// Shared UART definitions: transmit FSM one-hot encoding, baud divisor and frame-length helpers.
// The wishbone UART front end and the receiver import the same package.
package nexi_uart_pkg;

    typedef logic [5:0] tx_state_t;

    localparam tx_state_t S_TX_IDLE   = 6'b000001;
    localparam tx_state_t S_TX_START  = 6'b000010;
    localparam tx_state_t S_TX_DATA   = 6'b000100;
    localparam tx_state_t S_TX_PARITY = 6'b001000;
    localparam tx_state_t S_TX_STOP   = 6'b010000;
    localparam tx_state_t S_TX_DONE   = 6'b100000;

    // Clocks per bit, rounded to nearest.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    // Line bits in one frame: start + data + optional parity + stop bits.
    function automatic int frame_bits(input int data_width, input int parity_en, input int stop_bits);
        return 1 + data_width + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/nexi_uart_baud_gen.sv
// Bit-period timer: one-cycle bit_tick after every DIV enabled clocks, restarted by clear.
import nexi_uart_pkg::*;

module nexi_uart_baud_gen #(
    parameter int DIV = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign bit_tick = enable && (cnt == CW'(DIV - 1));

    // The counter stops at DIV-1 and wraps to zero on the tick, never beyond.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (bit_tick) cnt <= '0;
            else          cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/nexi_uart_tx_serializer.sv
// UART transmit serializer: four-phase command_send/done_ack handshake, LSB-first frame on tx_pin.
// Outputs decode directly from the registered one-hot state so reset forces the line high at once.
import nexi_uart_pkg::*;

module nexi_uart_tx_serializer #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  command_send,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  done_ack,
    output logic                  busy_o,
    output logic                  tx_pin
);

    localparam int DIV = uart_div(CLK_FREQ_HZ, BAUD);
    localparam int BW  = $clog2(DATA_WIDTH + 1);

    tx_state_t             state_q;
    tx_state_t             state_d;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] latched;
    logic [BW-1:0]         bit_cnt;
    logic                  bit_tick;
    logic                  data_last;
    logic                  stop_last;
    logic                  parity_bit;
    logic                  accept;

    assign accept     = (state_q == S_TX_IDLE) && command_send;
    assign data_last  = (bit_cnt == BW'(DATA_WIDTH - 1));
    assign stop_last  = (bit_cnt == BW'(STOP_BITS - 1));
    assign parity_bit = (^latched) ^ 1'(PARITY_ODD);

    // Baud timer only runs while a frame is on the line; each tick restarts it for the next bit.
    nexi_uart_baud_gen #(
        .DIV (DIV)
    ) u_baud (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear    (!busy_o),
        .enable   (busy_o),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_TX_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_TX_IDLE:   if (command_send) state_d = S_TX_START;
            S_TX_START:  if (bit_tick) state_d = S_TX_DATA;
            S_TX_DATA:   if (bit_tick && data_last)
                             state_d = (PARITY_EN != 0) ? S_TX_PARITY : S_TX_STOP;
            S_TX_PARITY: if (bit_tick) state_d = S_TX_STOP;
            S_TX_STOP:   if (bit_tick && stop_last) state_d = S_TX_DONE;
            // Wait for the request to drop so a held command_send cannot resend the byte.
            S_TX_DONE:   if (!command_send) state_d = S_TX_IDLE;
            default:     state_d = S_TX_IDLE;
        endcase
    end

    always_comb begin
        tx_pin   = 1'b1;
        busy_o   = 1'b0;
        done_ack = 1'b0;
        case (state_q)
            S_TX_IDLE:   done_ack = 1'b1;
            S_TX_START:  begin tx_pin = 1'b0;       busy_o = 1'b1; end
            S_TX_DATA:   begin tx_pin = shreg[0];   busy_o = 1'b1; end
            S_TX_PARITY: begin tx_pin = parity_bit; busy_o = 1'b1; end
            S_TX_STOP:   busy_o = 1'b1;
            S_TX_DONE:   done_ack = 1'b1;
            default:     done_ack = 1'b1;
        endcase
    end

    // bit_cnt indexes data bits in DATA and stop bits in STOP; it is zero on entry to each.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg   <= '0;
            latched <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            shreg   <= data;
            latched <= data;
            bit_cnt <= '0;
        end else if (bit_tick) begin
            if (state_q == S_TX_DATA) begin
                shreg   <= {1'b0, shreg[DATA_WIDTH-1:1]};
                bit_cnt <= data_last ? '0 : bit_cnt + BW'(1);
            end else if (state_q == S_TX_STOP) begin
                bit_cnt <= stop_last ? '0 : bit_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_nexi_uart_tx_serializer.sv
// Bench for nexi_uart_tx_serializer: a frame-level line model checked every cycle, plus directed
// frames decoded by a mid-bit sampler against hand-computed bit patterns and frame lengths.
module tb_nexi_uart_tx_serializer;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cs  = 2'b00;
    logic [7:0] d0  = 8'h00;
    logic [7:0] d1  = 8'h00;
    logic       ack0, ack1, busy0, busy1, tx0, tx1;
    wire  [1:0] ack  = {ack1, ack0};
    wire  [1:0] busy = {busy1, busy0};
    wire  [1:0] tx   = {tx1, tx0};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nexi_uart_tx_serializer #(
        .CLK_FREQ_HZ(16), .BAUD(1), .DATA_WIDTH(8),
        .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .command_send(cs[0]), .data(d0),
        .done_ack(ack0), .busy_o(busy0), .tx_pin(tx0)
    );

    nexi_uart_tx_serializer #(
        .CLK_FREQ_HZ(16), .BAUD(1), .DATA_WIDTH(8),
        .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
    ) dut_p (
        .clk_i(clk), .rst_i(rst), .command_send(cs[1]), .data(d1),
        .done_ack(ack1), .busy_o(busy1), .tx_pin(tx1)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- line model ----------------
    // Frame as line bits (index 0 = start), each held DIV clocks.
    function automatic logic [15:0] build_frame(input logic [7:0] b, input int par_en, input int stops);
        logic [15:0] f;
        int          p;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = b[i];
        p = 0;
        for (int i = 0; i < 8; i++) p = p ^ int'(b[i]);
        if (par_en != 0) f[9] = p[0];
        return f;
    endfunction

    int          m_phase[2];  // 0 idle, 1 frame on line, 2 finished awaiting request drop
    int          m_t[2];
    int          m_len[2];
    logic [15:0] m_bits[2];

    function automatic logic [7:0] din(input int k);
        return (k == 0) ? d0 : d1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_phase[k] <= 0;
                m_t[k]     <= 0;
                m_len[k]   <= 0;
                m_bits[k]  <= '1;
            end else if (m_phase[k] == 0) begin
                if (cs[k]) begin
                    m_bits[k]  <= build_frame(din(k), k, k + 1);
                    m_len[k]   <= (10 + 2 * k) * DIV;
                    m_t[k]     <= 0;
                    m_phase[k] <= 1;
                end
            end else if (m_phase[k] == 1) begin
                if (m_t[k] + 1 == m_len[k]) m_phase[k] <= 2;
                else                        m_t[k] <= m_t[k] + 1;
            end else if (!cs[k]) begin
                m_phase[k] <= 0;
            end
        end
    end

    // ---------------- scoreboard: every cycle ----------------
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                logic       e_tx;
                logic       on_line;
                on_line = (m_phase[k] == 1);
                e_tx    = on_line ? m_bits[k][m_t[k] / DIV] : 1'b1;
                check($sformatf("tx_pin[%0d]", k), 32'(tx[k]), 32'(e_tx));
                check($sformatf("busy_o[%0d]", k), 32'(busy[k]), 32'(on_line));
                check($sformatf("done_ack[%0d]", k), 32'(ack[k]), 32'(!on_line));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic set_data(input int k, input logic [7:0] v);
        if (k == 0) d0 = v;
        else        d1 = v;
    endtask

    task automatic run_frame(input int k, input logic [7:0] d, input logic [7:0] d_late,
                             input bit hold, input int nbits,
                             output logic [15:0] seen, output int t0, output int len);
        int n;
        seen = '0;
        cs[k] = 1'b1;
        set_data(k, d);
        @(negedge clk);
        n = 0;
        while (ack[k] && n < 8) begin @(negedge clk); n++; end
        check("accept_ack_low", 32'(ack[k]), 32'd0);
        t0 = cyc;
        if (!hold) cs[k] = 1'b0;
        set_data(k, d_late);
        repeat (DIV / 2) @(negedge clk);
        seen[0] = tx[k];
        for (int i = 1; i < nbits; i++) begin
            repeat (DIV) @(negedge clk);
            seen[i] = tx[k];
        end
        n = 0;
        while (!ack[k] && n < 400) begin @(negedge clk); n++; end
        len = cyc - t0;
    endtask

    initial begin
        logic [15:0] seen;
        int          t0, t1, len;

        // reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_tx", 32'(tx0), 32'd1);
        check("rst_ack", 32'(ack0), 32'd1);
        check("rst_busy", 32'(busy0), 32'd0);
        repeat (2) @(negedge clk);

        // 1: A5 frame, start-bit to done_ack latency
        run_frame(0, 8'hA5, 8'(32'($urandom_range(0, 255))), 1'b0, 10, seen, t0, len);
        check("a5_line_bits", 32'(seen[9:0]), 32'h34A);
        check("a5_len", 32'(len), 32'd160);
        repeat (3) @(negedge clk);

        // 2: request held through the frame, one frame only
        run_frame(0, 8'h3C, 8'h3C, 1'b1, 10, seen, t0, len);
        check("3c_byte", 32'(seen[8:1]), 32'h3C);
        check("3c_len", 32'(len), 32'd160);
        repeat (20) @(negedge clk);
        check("held_no_resend_busy", 32'(busy0), 32'd0);
        check("held_no_resend_ack", 32'(ack0), 32'd1);
        cs[0] = 1'b0;
        @(negedge clk);
        run_frame(0, 8'hC3, 8'h00, 1'b0, 10, seen, t0, len);
        check("c3_byte", 32'(seen[8:1]), 32'hC3);
        repeat (2) @(negedge clk);

        // 3: data changes to FF mid-frame are ignored
        run_frame(0, 8'h00, 8'hFF, 1'b0, 10, seen, t0, len);
        check("00_line_bits", 32'(seen[9:0]), 32'h200);
        repeat (2) @(negedge clk);

        // 4: even parity, two stop bits
        run_frame(1, 8'h07, 8'(32'($urandom_range(0, 255))), 1'b0, 12, seen, t0, len);
        check("p07_byte", 32'(seen[8:1]), 32'h07);
        check("p07_parity", 32'(seen[9]), 32'd1);
        check("p07_stops", 32'(seen[11:10]), 32'h3);
        check("p07_len", 32'(len), 32'd192);
        repeat (2) @(negedge clk);

        // 5: asynchronous reset during data bit 3
        cs[0] = 1'b1;
        d0 = 8'h96;
        @(negedge clk);
        cs[0] = 1'b0;
        repeat (4 * DIV + 8 - 1) @(negedge clk);
        check("pre_rst_busy", 32'(busy0), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", 32'(tx0), 32'd1);
        check("async_rst_ack", 32'(ack0), 32'd1);
        check("async_rst_busy", 32'(busy0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_frame(0, 8'h69, 8'h00, 1'b0, 10, seen, t0, len);
        check("post_rst_byte", 32'(seen[8:1]), 32'h69);
        check("post_rst_len", 32'(len), 32'd160);
        repeat (2) @(negedge clk);

        // 6: back-to-back frames, two idle clocks between them
        run_frame(0, 8'h55, 8'h00, 1'b0, 10, seen, t0, len);
        check("b2b_55_byte", 32'(seen[8:1]), 32'h55);
        check("b2b_55_len", 32'(len), 32'd160);
        @(negedge clk);
        run_frame(0, 8'hAA, 8'h00, 1'b0, 10, seen, t1, len);
        check("b2b_aa_byte", 32'(seen[8:1]), 32'hAA);
        check("b2b_gap", 32'(t1 - t0 - 160), 32'd2);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
